auth_resp_ctrl: RTL and testbench

Sequencing controller for the authentication responder blocks (digests, certificate, challenge answer). Accepts one decoded request at a time and validates protocol version, message type and slot. Drives the `Enable` of exactly one responder and waits for its `Ack_out` under a timeout. It then presents a response-valid handshake toward the transport, with a select that steers the header/payload mux, or an ERROR response when validation or the responder fails.

---
 rtl/auth_resp_ctrl_pkg.sv | 53 +++++
 rtl/auth_resp_ctrl_ack_timer.sv | 27 ++
 rtl/auth_resp_ctrl.sv | 156 +++++++++++++++
 tb/tb_auth_resp_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/auth_resp_ctrl_pkg.sv
// Shared protocol codes and types for the authentication responder sequencer:
// request/response/error codes, resp_sel encodings, FSM states and request validation.
package auth_resp_ctrl_pkg;

    localparam logic [7:0] SUPPORTED_VERSION        = 8'h01;

    localparam logic [7:0] REQ_GET_DIGESTS          = 8'h81;
    localparam logic [7:0] REQ_GET_CERTIFICATE      = 8'h82;
    localparam logic [7:0] REQ_CHALLENGE            = 8'h83;

    localparam logic [7:0] RSP_DIGESTS              = 8'h01;
    localparam logic [7:0] RSP_CERTIFICATE          = 8'h02;
    localparam logic [7:0] RSP_CHALLENGE_AUTH       = 8'h03;
    localparam logic [7:0] RSP_ERROR                = 8'h7F;

    localparam logic [7:0] ERR_NONE                 = 8'h00;
    localparam logic [7:0] ERR_INVALID              = 8'h01;
    localparam logic [7:0] ERR_UNSUPPORTED_PROTOCOL = 8'h02;
    localparam logic [7:0] ERR_UNSPECIFIED          = 8'h04;

    localparam logic [1:0] RESP_SEL_DIGESTS         = 2'd0;
    localparam logic [1:0] RESP_SEL_CERTIFICATE     = 2'd1;
    localparam logic [1:0] RESP_SEL_CHALLENGE_AUTH  = 2'd2;
    localparam logic [1:0] RESP_SEL_ERROR           = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_RESP     = 2'd2
    } state_t;

    // Returns ERR_NONE for an acceptable request, else the error code to report.
    // Checks are in priority order: version, then type, then slot range.
    function automatic logic [7:0] check_request(
        input logic [7:0] version,
        input logic [7:0] msg_type,
        input logic [7:0] param1,
        input int         num_slots
    );
        logic [7:0] err;
        err = ERR_NONE;
        if (version != SUPPORTED_VERSION) begin
            err = ERR_UNSUPPORTED_PROTOCOL;
        end else if (msg_type != REQ_GET_DIGESTS && msg_type != REQ_GET_CERTIFICATE &&
                     msg_type != REQ_CHALLENGE) begin
            err = ERR_INVALID;
        end else if (msg_type != REQ_GET_DIGESTS && int'(param1) >= num_slots) begin
            err = ERR_INVALID;
        end
        return err;
    endfunction

endpackage

// File: rtl/auth_resp_ctrl_ack_timer.sv
// Responder ack timeout: saturating count of enable-high cycles, flags the
// cycle in which the enable has been high for ACK_TIMEOUT cycles.
module auth_ack_timer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_L,
    input  logic clear,
    input  logic run,
    output logic expired
);
    logic [7:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            count_reg <= 8'd0;
        end else if (clear) begin
            count_reg <= 8'd0;
        end else if (run && count_reg != 8'hFF) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    // count_reg holds completed enable cycles; the current one completes at this edge.
    assign expired = run && (count_reg == 8'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/auth_resp_ctrl.sv
// Sequencer for the digest/certificate/challenge responders: validates a request,
// enables one responder, waits for its ack under a timeout, then presents the response.
module auth_resp_ctrl
    import auth_resp_ctrl_pkg::*;
#(
    parameter int NUM_SLOTS   = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_version,
    input  logic [7:0] req_msg_type,
    input  logic [7:0] req_param1,
    output logic       digest_en,
    output logic       cert_en,
    output logic       chal_en,
    output logic [7:0] slot_sel,
    input  logic       digest_ack,
    input  logic       cert_ack,
    input  logic       chal_ack,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [1:0] resp_sel,
    output logic [7:0] err_code
);
    state_t     state_reg, state_next;
    logic       req_ready_reg, req_ready_next;
    logic [2:0] en_reg, en_next;            // bit 0 digest, 1 cert, 2 chal
    logic [7:0] slot_sel_reg, slot_sel_next;
    logic       resp_valid_reg, resp_valid_next;
    logic [1:0] resp_sel_reg, resp_sel_next;
    logic [7:0] err_code_reg, err_code_next;
    logic [7:0] req_err;
    logic [2:0] ack_vec;
    logic [2:0] sel_ack;
    logic       timer_expired;

    assign ack_vec = {chal_ack, cert_ack, digest_ack};

    // Only the ack of the currently enabled responder counts.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ack
            assign sel_ack[gi] = en_reg[gi] & ack_vec[gi];
        end
    endgenerate

    auth_ack_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset_L(reset_L),
        .clear  (state_reg != ST_WAIT_ACK),
        .run    (state_reg == ST_WAIT_ACK),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_reg      <= ST_IDLE;
            req_ready_reg  <= 1'b0;
            en_reg         <= 3'b000;
            slot_sel_reg   <= 8'd0;
            resp_valid_reg <= 1'b0;
            resp_sel_reg   <= 2'd0;
            err_code_reg   <= 8'd0;
        end else begin
            state_reg      <= state_next;
            req_ready_reg  <= req_ready_next;
            en_reg         <= en_next;
            slot_sel_reg   <= slot_sel_next;
            resp_valid_reg <= resp_valid_next;
            resp_sel_reg   <= resp_sel_next;
            err_code_reg   <= err_code_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        en_next         = en_reg;
        slot_sel_next   = slot_sel_reg;
        resp_valid_next = resp_valid_reg;
        resp_sel_next   = resp_sel_reg;
        err_code_next   = err_code_reg;
        req_err         = check_request(req_version, req_msg_type, req_param1, NUM_SLOTS);

        case (state_reg)
            ST_IDLE: begin
                if (req_valid && req_ready_reg) begin
                    slot_sel_next = req_param1;
                    if (req_err != ERR_NONE) begin
                        state_next      = ST_RESP;
                        resp_valid_next = 1'b1;
                        resp_sel_next   = RESP_SEL_ERROR;
                        err_code_next   = req_err;
                    end else begin
                        state_next = ST_WAIT_ACK;
                        case (req_msg_type)
                            REQ_GET_DIGESTS:     en_next = 3'b001;
                            REQ_GET_CERTIFICATE: en_next = 3'b010;
                            default:             en_next = 3'b100;
                        endcase
                    end
                end
            end
            ST_WAIT_ACK: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (|sel_ack) begin
                    state_next      = ST_RESP;
                    en_next         = 3'b000;
                    resp_valid_next = 1'b1;
                    err_code_next   = ERR_NONE;
                    if (en_reg[1]) begin
                        resp_sel_next = RESP_SEL_CERTIFICATE;
                    end else if (en_reg[2]) begin
                        resp_sel_next = RESP_SEL_CHALLENGE_AUTH;
                    end else begin
                        resp_sel_next = RESP_SEL_DIGESTS;
                    end
                end else if (timer_expired) begin
                    state_next      = ST_RESP;
                    en_next         = 3'b000;
                    resp_valid_next = 1'b1;
                    resp_sel_next   = RESP_SEL_ERROR;
                    err_code_next   = ERR_UNSPECIFIED;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_next      = ST_IDLE;
                    resp_valid_next = 1'b0;
                    resp_sel_next   = 2'd0;
                    err_code_next   = ERR_NONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                en_next    = 3'b000;
            end
        endcase

        req_ready_next = (state_next == ST_IDLE);
    end

    assign req_ready  = req_ready_reg;
    assign digest_en  = en_reg[0];
    assign cert_en    = en_reg[1];
    assign chal_en    = en_reg[2];
    assign slot_sel   = slot_sel_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_sel   = resp_sel_reg;
    assign err_code   = err_code_reg;

endmodule

// File: tb/tb_auth_resp_ctrl.sv
// Scoreboard bench for auth_resp_ctrl: driver pushes model expectations on accept,
// a negedge monitor pops and checks each response, latency and enable activity.
module tb_auth_resp_ctrl;
    localparam int NUM_SLOTS   = 8;
    localparam int ACK_TIMEOUT = 16;
    localparam int NEVER       = 255;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_version = 8'd0;
    logic [7:0] req_msg_type = 8'd0;
    logic [7:0] req_param1 = 8'd0;
    logic       digest_en, cert_en, chal_en;
    logic [7:0] slot_sel;
    logic       digest_ack = 1'b0, cert_ack = 1'b0, chal_ack = 1'b0;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [1:0] resp_sel;
    logic [7:0] err_code;

    auth_resp_ctrl #(.NUM_SLOTS(NUM_SLOTS), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .reset_L(reset_L),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_version(req_version), .req_msg_type(req_msg_type), .req_param1(req_param1),
        .digest_en(digest_en), .cert_en(cert_en), .chal_en(chal_en), .slot_sel(slot_sel),
        .digest_ack(digest_ack), .cert_ack(cert_ack), .chal_ack(chal_ack),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_sel(resp_sel), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] err;
        int         en_idx;   // 0 digest, 1 cert, 2 chal, 3 none
        int         cycles;   // enable-high cycles == accept-to-response latency
        logic [7:0] slot;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   active_delay = NEVER;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference: the responder acks after seeing its enable for d+1 cycles.
    function automatic exp_t model(input logic [7:0] ver, input logic [7:0] typ,
                                   input logic [7:0] p1, input int d);
        exp_t e;
        e.slot = p1; e.en_idx = 3; e.cycles = 0; e.sel = 2'd0; e.err = 8'h00;
        if (ver != 8'h01) begin
            e.sel = 2'd3; e.err = 8'h02;
        end else if (typ < 8'h81 || typ > 8'h83) begin
            e.sel = 2'd3; e.err = 8'h01;
        end else if (typ != 8'h81 && int'(p1) >= NUM_SLOTS) begin
            e.sel = 2'd3; e.err = 8'h01;
        end else begin
            e.en_idx = int'(typ) - 'h81;
            if (d + 1 <= ACK_TIMEOUT) begin
                e.cycles = d + 1;
                e.sel    = 2'(e.en_idx);
            end else begin
                e.cycles = ACK_TIMEOUT;
                e.sel    = 2'd3;
                e.err    = 8'h04;
            end
        end
        return e;
    endfunction

    // Responders: selected one acks per active_delay, idle ones emit stray acks.
    initial begin
        int rcnt [3];
        logic [2:0] env, ackv;
        rcnt = '{0, 0, 0};
        forever begin
            @(posedge clk);
            #1;
            env = {chal_en, cert_en, digest_en};
            for (int i = 0; i < 3; i++) begin
                if (env[i]) begin
                    rcnt[i]++;
                    ackv[i] = (rcnt[i] > active_delay);
                end else begin
                    rcnt[i] = 0;
                    ackv[i] = ($urandom_range(0, 3) == 0);
                end
            end
            {chal_ack, cert_ack, digest_ack} = ackv;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            resp_ready = ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor
    bit         mon_busy = 0;
    bit         prev_valid = 0;
    int         mon_cycles = 0;
    int         mon_en_cnt [3];
    logic [1:0] held_sel;
    logic [7:0] held_err;
    exp_t       mon_e;

    always @(negedge clk) begin
        logic [2:0] env;
        env = {chal_en, cert_en, digest_en};
        if (!reset_L) begin
            mon_busy   = 0;
            prev_valid = 0;
        end else begin
            if (resp_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_sel", resp_sel, mon_e.sel);
                    check("err_code", err_code, mon_e.err);
                    check("latency", mon_cycles, mon_e.cycles);
                    for (int i = 0; i < 3; i++)
                        check($sformatf("en%0d_cycles", i), mon_en_cnt[i],
                              (i == mon_e.en_idx) ? mon_e.cycles : 0);
                    check("en_at_resp", env, 0);
                    $display("resp: sel=%0d err=%02h latency=%0d slot=%0d", resp_sel,
                             err_code, mon_cycles, mon_e.slot);
                end
                check("req_ready_at_resp", req_ready, 0);
                held_sel = resp_sel;
                held_err = err_code;
                mon_busy = 0;
            end else if (resp_valid) begin
                check("held_sel", resp_sel, held_sel);
                check("held_err", err_code, held_err);
                check("req_ready_held", req_ready, 0);
            end else begin
                check("idle_sel_err", {resp_sel, err_code}, 0);
                if (mon_busy) begin
                    mon_cycles++;
                    for (int i = 0; i < 3; i++)
                        if (env[i]) mon_en_cnt[i]++;
                    check("req_ready_busy", req_ready, 0);
                    if (env != 3'b000) begin
                        check("onehot_en", ($countones(env) > 1) ? 1 : 0, 0);
                        if (exp_q.size() > 0) check("slot_sel", slot_sel, exp_q[0].slot);
                    end
                end else begin
                    check("en_idle", env, 0);
                end
            end
            prev_valid = resp_valid;
            if (req_valid && req_ready) begin
                mon_busy   = 1;
                mon_cycles = 0;
                mon_en_cnt = '{0, 0, 0};
            end
        end
    end

    task automatic do_req(input logic [7:0] ver, input logic [7:0] typ,
                          input logic [7:0] p1, input int d);
        int guard;
        bit ok;
        @(posedge clk);
        #1;
        req_version  = ver;
        req_msg_type = typ;
        req_param1   = p1;
        req_valid    = 1'b1;
        guard = 0;
        ok    = 0;
        while (!ok && guard < 400) begin
            @(negedge clk);
            if (req_ready) ok = 1;
            else guard++;
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        active_delay = d;
        exp_q.push_back(model(ver, typ, p1, d));
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (4) @(posedge clk);
    endtask

    logic [7:0] t_ver [6] = '{8'h01, 8'h01, 8'h02, 8'h01, 8'h01, 8'h01};
    logic [7:0] t_typ [6] = '{8'h83, 8'h82, 8'h81, 8'h81, 8'h82, 8'h83};
    logic [7:0] t_p1  [6] = '{8'd3,  8'd9,  8'd0,  8'd0,  8'd2,  8'd7};
    int         t_d   [6] = '{1,     1,     1,     2,     NEVER, 15};

    initial begin
        logic [7:0] v, t, p;
        int d, r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_en", {chal_en, cert_en, digest_en}, 0);
        check("rst_sel_err", {resp_sel, err_code}, 0);
        check("rst_slot_sel", slot_sel, 0);
        @(posedge clk);
        #1 reset_L = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rel_req_ready", req_ready, 1);

        for (int i = 0; i < 6; i++) do_req(t_ver[i], t_typ[i], t_p1[i], t_d[i]);
        drain();

        for (int n = 0; n < 150; n++) begin
            v = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h01;
            t = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(8'h81 + $urandom_range(0, 2));
            p = 8'($urandom_range(0, 10));
            r = $urandom_range(0, 9);
            case (r)
                5:       d = 14;
                6:       d = 15;
                7:       d = 16;
                8:       d = NEVER;
                9:       d = $urandom_range(1, 20);
                default: d = $urandom_range(1, 6);
            endcase
            do_req(v, t, p, d);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();

        // Reset while a responder is enabled discards the transaction.
        do_req(8'h01, 8'h82, 8'd1, NEVER);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("cert_en_before_rst", cert_en, 1);
        @(posedge clk);
        #1 reset_L = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_en", {chal_en, cert_en, digest_en}, 0);
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_req_ready", req_ready, 0);
        exp_q.delete();
        @(posedge clk);
        #1 reset_L = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_rel_req_ready", req_ready, 1);

        do_req(8'h01, 8'h83, 8'd1, 2);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
